ndev_debug_decoder: RTL and testbench



---
 rtl/ndev_pkg.sv | 27 ++
 rtl/byte_fifo.sv | 55 +++++
 rtl/ndev_debug_decoder.sv | 156 +++++++++++++++
 tb/tb_ndev_debug_decoder.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ndev_pkg.sv
// Shared constants and types for the NDEV_LED debug bus decoder.
//   START_PREV / SER_MARK : the 0x0F -> 0x8F pair that opens a serial session;
//                           SER_MARK alone terminates a serial byte.
//   WIN_A / WIN_B         : boot "winner" codes that set win_seen.
//   is_clear_code()       : codes that clear win_seen.
//   state_e               : decoder mode, RAW capture or bit-serial.
package ndev_pkg;

  localparam logic [7:0] START_PREV = 8'h0F;
  localparam logic [7:0] SER_MARK   = 8'h8F;
  localparam logic [7:0] WIN_A      = 8'h88;
  localparam logic [7:0] WIN_B      = 8'h25;

  typedef enum logic {
    RAW,
    SERIAL
  } state_e;

  function automatic logic is_win_code(input logic [7:0] v);
    return (v == WIN_A) || (v == WIN_B);
  endfunction

  function automatic logic is_clear_code(input logic [7:0] v);
    return v inside {8'hC3, 8'hDA, 8'hE1, 8'h0D, 8'h1D};
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO.
//   CLK, RST : clock, synchronous active-high reset (empties the FIFO)
//   push     : write wdata this cycle; dropped (drop=1) when full with no pop
//   pop      : consume rdata this cycle; ignored when empty
//   rdata    : current head byte, valid while !empty
//   full, empty, level : occupancy status
//   drop     : a push is being lost this cycle
module byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);
  localparam logic [AW:0] One    = (AW+1)'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wptr_q, rptr_q;
  logic [7:0]  mem_q [DEPTH];
  logic        push_ok, pop_ok;

  assign level   = wptr_q - rptr_q;
  assign empty   = (wptr_q == rptr_q);
  assign full    = (level == DepthW);
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + One;
      if (pop_ok)  rptr_q <= rptr_q + One;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ndev_debug_decoder.sv
// Capture stage for the 8-bit NDEV_LED debug GPIO bus, feeding the UART byte loader.
//   CLK, RST    : 12 MHz clock, synchronous active-high reset
//   dbg_in      : raw asynchronous debug pins
//   freeze      : hold off change capture and force RAW mode
//   out_valid/out_data/out_ready : FIFO head handshake towards uart_tx
//   serial_mode : decoder is in the bit-serial sub-protocol
//   win_seen    : sticky boot-winner flag (cleared by the clear codes)
//   overflow    : sticky, a byte was dropped on a full FIFO
//   fifo_level  : current FIFO occupancy
module ndev_debug_decoder
  import ndev_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter logic [23:0] SERIAL_TIMEOUT = 24'd1_200_000
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [7:0]                    dbg_in,
  input  logic                          freeze,
  output logic                          out_valid,
  output logic [7:0]                    out_data,
  input  logic                          out_ready,
  output logic                          serial_mode,
  output logic                          win_seen,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  logic [7:0]  sync_q, sample_q, last_q, last_d;
  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [23:0] tmo_q, tmo_d;
  logic        win_q, win_d;
  logic        ovf_q;

  logic        evt, data_bit;
  logic        push;
  logic [7:0]  push_data;
  logic        fifo_empty, fifo_full, fifo_drop, pop;

  assign evt      = (sample_q != last_q) && !freeze;
  // Data bit: bit7 rising with only bit0 possibly set alongside it.
  assign data_bit = !last_q[7] && sample_q[7] && (sample_q[6:1] == 6'd0);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    tmo_d     = tmo_q;
    win_d     = win_q;
    push      = 1'b0;
    push_data = sample_q;

    if (evt) last_d = sample_q;

    unique case (state_q)
      RAW: begin
        tmo_d = '0;
        if (evt) begin
          push = 1'b1;
          if (is_win_code(sample_q)) begin
            win_d = 1'b1;
          end else if (is_clear_code(sample_q)) begin
            win_d = 1'b0;
          end
          if ((sample_q == SER_MARK) && (last_q == START_PREV)) begin
            state_d   = SERIAL;
            bit_cnt_d = '0;
            shreg_d   = '0;
          end
        end
      end
      SERIAL: begin
        if (freeze) begin
          state_d   = RAW;
          bit_cnt_d = '0;
          shreg_d   = '0;
          tmo_d     = '0;
        end else if (evt) begin
          tmo_d = '0;
          if (data_bit) begin
            // Bits beyond the eighth are ignored until the terminator.
            if (bit_cnt_q < 4'd8) begin
              shreg_d   = {shreg_q[6:0], sample_q[0]};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else if (sample_q == SER_MARK) begin
            // Short frames are dropped without a trace.
            push      = (bit_cnt_q == 4'd8);
            push_data = shreg_q;
            bit_cnt_d = '0;
            shreg_d   = '0;
          end
        end else if (tmo_q >= SERIAL_TIMEOUT) begin
          state_d   = RAW;
          bit_cnt_d = '0;
          shreg_d   = '0;
          tmo_d     = '0;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end
      default: state_d = RAW;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      // Synchroniser starts at the idle value so reset does not fake a change.
      sync_q    <= 8'h55;
      sample_q  <= 8'h55;
      last_q    <= 8'h55;
      state_q   <= RAW;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      tmo_q     <= '0;
      win_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      sync_q    <= dbg_in;
      sample_q  <= sync_q;
      last_q    <= last_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      tmo_q     <= tmo_d;
      win_q     <= win_d;
      if (fifo_drop) ovf_q <= 1'b1;
    end
  end

  assign pop = !fifo_empty && out_ready;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop),
    .level (fifo_level)
  );

  assign out_valid   = !fifo_empty;
  assign serial_mode = (state_q == SERIAL);
  assign win_seen    = win_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_ndev_debug_decoder.sv
module tb_ndev_debug_decoder;

  localparam int unsigned DEPTH = 4;
  localparam logic [23:0] TMO   = 24'd1000;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] dbg_in = 8'h55;
  logic       freeze = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       serial_mode;
  logic       win_seen;
  logic       overflow;
  logic [2:0] fifo_level;

  ndev_debug_decoder #(
    .FIFO_DEPTH     (DEPTH),
    .SERIAL_TIMEOUT (TMO)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .dbg_in      (dbg_in),
    .freeze      (freeze),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .serial_mode (serial_mode),
    .win_seen    (win_seen),
    .overflow    (overflow),
    .fifo_level  (fifo_level)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got_v, exp_v);
    end
  endtask

  // Every byte the consumer actually takes, in order.
  logic [7:0] got_q[$];
  always @(negedge CLK) begin
    if (!RST && out_valid && out_ready) got_q.push_back(out_data);
  end

  // Reference model: works on whole bus values, one call per driven value.
  logic [7:0] exp_q[$];
  logic [7:0] m_last   = 8'h55;
  bit         m_serial = 1'b0;
  int         m_nbits  = 0;
  int         m_acc    = 0;
  bit         m_win    = 1'b0;
  bit         m_ovf    = 1'b0;
  bit         m_frz    = 1'b0;
  bit         m_pop_now = 1'b0;

  task automatic model_push(input logic [7:0] b);
    if ((exp_q.size() - got_q.size() >= int'(DEPTH)) && !m_pop_now) m_ovf = 1'b1;
    else exp_q.push_back(b);
  endtask

  task automatic model_apply(input logic [7:0] v);
    if (m_frz || v == m_last) return;
    if (!m_serial) begin
      model_push(v);
      if (v == 8'h88 || v == 8'h25) m_win = 1'b1;
      else if (v == 8'hC3 || v == 8'hDA || v == 8'hE1 || v == 8'h0D || v == 8'h1D) m_win = 1'b0;
      if (v == 8'h8F && m_last == 8'h0F) begin
        m_serial = 1'b1;
        m_nbits  = 0;
        m_acc    = 0;
      end
    end else begin
      if (m_last < 8'h80 && (v == 8'h80 || v == 8'h81)) begin
        if (m_nbits < 8) begin
          m_acc = m_acc * 2 + (v == 8'h81 ? 1 : 0);
          m_nbits++;
        end
      end else if (v == 8'h8F) begin
        if (m_nbits == 8) model_push(8'(m_acc));
        m_nbits = 0;
        m_acc   = 0;
      end
    end
    m_last = v;
  endtask

  task automatic model_reset();
    exp_q.delete();
    got_q.delete();
    m_last = 8'h55; m_serial = 1'b0; m_nbits = 0; m_acc = 0;
    m_win = 1'b0; m_ovf = 1'b0; m_frz = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Ten-cycle hold; in random mode ready is random but forced high at the end so
  // each byte drains before the next value is driven.
  task automatic hold(input bit rnd);
    for (int i = 0; i < 10; i++) begin
      if (rnd) out_ready = (i >= 7) ? 1'b1 : 1'($urandom_range(0, 1));
      tick(1);
    end
  endtask

  task automatic drive(input logic [7:0] v, input bit rnd);
    dbg_in = v;
    model_apply(v);
    hold(rnd);
    check_val("serial_mode", 32'(serial_mode), 32'(m_serial));
    check_val("win_seen", 32'(win_seen), 32'(m_win));
  endtask

  task automatic set_freeze(input bit f);
    freeze = f;
    m_frz  = f;
    if (f) begin
      m_serial = 1'b0; m_nbits = 0; m_acc = 0;
    end else begin
      model_apply(dbg_in);
    end
  endtask

  task automatic compare_stream(input string tag);
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 80 && got_q.size() < exp_q.size(); i++) tick(1);
    tick(5);
    check_val({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_val({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] codes [7];
    int nb;
    codes = '{8'h88, 8'h25, 8'hC3, 8'hDA, 8'hE1, 8'h0D, 8'h1D};

    // Reset state
    tick(4);
    RST = 1'b0;
    tick(1);
    check_val("rst_out_valid", 32'(out_valid), 0);
    check_val("rst_serial", 32'(serial_mode), 0);
    check_val("rst_win", 32'(win_seen), 0);
    check_val("rst_overflow", 32'(overflow), 0);
    check_val("rst_level", 32'(fifo_level), 0);

    // RAW capture and latency
    out_ready = 1'b1;
    dbg_in = 8'h10;
    model_apply(8'h10);
    tick(2);
    check_val("lat_edge2", 32'(out_valid), 0);
    tick(1);
    check_val("lat_edge3", 32'(out_valid), 1);
    tick(7);
    drive(8'h11, 0);
    drive(8'h11, 0);
    drive(8'h12, 0);
    compare_stream("raw");

    // Serial byte 0xA5
    drive(8'h0F, 0);
    drive(8'h8F, 0);
    check_val("ser_entered", 32'(serial_mode), 1);
    b = 8'hA5;
    for (int k = 7; k >= 0; k--) begin
      drive(8'h00, 0);
      drive(8'h80 | {7'd0, b[k]}, 0);
    end
    drive(8'h8F, 0);
    check_val("ser_exp_count", 32'(exp_q.size()), 3);
    compare_stream("serial");

    // Short frame, then timeout
    for (int k = 0; k < 5; k++) begin
      drive(8'h00, 0);
      drive(8'h81, 0);
    end
    drive(8'h8F, 0);
    compare_stream("short");
    tick(930);
    check_val("tmo_before", 32'(serial_mode), 1);
    tick(100);
    check_val("tmo_after", 32'(serial_mode), 0);
    m_serial = 1'b0; m_nbits = 0; m_acc = 0;
    drive(8'h33, 0);
    compare_stream("post_tmo");

    // Win / clear / freeze
    drive(8'h25, 0);
    check_val("win_25", 32'(win_seen), 1);
    drive(8'hC3, 0);
    check_val("win_c3", 32'(win_seen), 0);
    drive(8'h88, 0);
    check_val("win_88", 32'(win_seen), 1);
    set_freeze(1'b1);
    drive(8'h44, 0);
    check_val("frz_level", 32'(fifo_level), 0);
    drive(8'h88, 0);
    set_freeze(1'b0);
    hold(0);
    compare_stream("freeze");

    // Randomised traffic against the model
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: drive(8'($urandom), 1);
        4, 5, 6: begin
          b  = 8'($urandom);
          nb = $urandom_range(6, 9);
          drive(8'h0F, 1);
          drive(8'h8F, 1);
          for (int k = 0; k < nb; k++) begin
            drive(8'h00, 1);
            if (k < 8) drive(8'h80 | {7'd0, b[7-k]}, 1);
            else drive(8'h80 | 8'($urandom_range(0, 1)), 1);
          end
          drive(8'h8F, 1);
        end
        7: begin
          set_freeze(1'b1);
          drive(8'($urandom), 1);
          set_freeze(1'b0);
          hold(1);
          check_val("rnd_frz_serial", 32'(serial_mode), 32'(m_serial));
        end
        default: drive(codes[$urandom_range(0, 6)], 1);
      endcase
    end
    compare_stream("random");
    check_val("rnd_overflow", 32'(overflow), 0);

    // Overflow with a 4-entry FIFO
    if (serial_mode) begin
      set_freeze(1'b1);
      hold(0);
      set_freeze(1'b0);
      hold(0);
      compare_stream("pre_ovf");
    end
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) drive(8'hA1 + 8'(k), 0);
    check_val("ovf_level", 32'(fifo_level), 4);
    check_val("ovf_flag", 32'(overflow), 32'(m_ovf));
    check_val("ovf_flag_set", 32'(overflow), 1);
    dbg_in = 8'hA7;
    m_pop_now = 1'b1;
    model_apply(8'hA7);
    m_pop_now = 1'b0;
    tick(2);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    tick(7);
    check_val("full_push_pop_level", 32'(fifo_level), 4);
    compare_stream("ovf");
    check_val("ovf_sticky", 32'(overflow), 1);

    // Reset in the middle of a serial byte with bytes queued
    out_ready = 1'b0;
    drive(8'h3C, 0);
    drive(8'h0F, 0);
    drive(8'h8F, 0);
    for (int k = 0; k < 4; k++) begin
      drive(8'h00, 0);
      drive(8'h81, 0);
    end
    check_val("pre_rst_level", 32'(fifo_level), 3);
    RST = 1'b1;
    dbg_in = 8'h55;
    tick(1);
    check_val("mid_rst_valid", 32'(out_valid), 0);
    check_val("mid_rst_serial", 32'(serial_mode), 0);
    check_val("mid_rst_level", 32'(fifo_level), 0);
    tick(2);
    RST = 1'b0;
    model_reset();
    tick(1);
    check_val("post_rst_overflow", 32'(overflow), 0);
    check_val("post_rst_win", 32'(win_seen), 0);
    out_ready = 1'b1;
    drive(8'h8F, 0);
    check_val("lone_8f_serial", 32'(serial_mode), 0);
    compare_stream("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
